data_memory_responder: RTL
==========================

// Module: data_memory_responder
// PURPOSE
//  Multi-cycle data-memory target that answers the pipeline's memory-stage load/store requests
//  over a valid/ready request channel and a valid/ready response channel.
//  Implements RV32I load/store widths, alignment and range checking, and a configurable access latency.
//  Sits behind the MEM stage; mem_busy drives the pipeline stall.
//  Holds one outstanding request at a time.
// PARAMETERS
//  DEPTH_WORDS  1024   number of 32-bit words in the storage array
//  LATENCY      2      wait cycles between request accept and response (0 allowed)
//  BASE_ADDR    32'h0  byte address mapped to word 0
// PORTS
//  clock       in   1   rising-edge clock
//  reset       in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request
//  req_write   in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (load: 0 LB,1 LH,2 LW,4 LBU,5 LHU; store: 0 SB,1 SH,2 SW)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (byte/half in low bits)
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester accepts response
//  rsp_rdata   out  32  load result, extended; 0 for stores and errors
//  rsp_error   out  1   misaligned, out-of-range or illegal funct3
//  mem_busy    out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, RESP.
//  - req_ready = (state==IDLE). Handshake occurs when req_valid && req_ready. All request fields are registered at accept.
//  - IDLE -> WAIT on accept when LATENCY>0; counter loads LATENCY-1.
//  - IDLE -> RESP on accept when LATENCY==0.
//  - WAIT: counter decrements each cycle; at 0 -> RESP.
//  - Access commit occurs on the transition into RESP: store written to array, load data captured.
//    rsp_valid, rsp_rdata and rsp_error are registered and asserted from the first RESP cycle.
//  - Latency: accept in cycle T -> rsp_valid high in cycle T+1+LATENCY.
//  - RESP: outputs held stable until rsp_valid && rsp_ready; then -> IDLE.
//    rsp_valid drops the next cycle. No new accept in the handshake cycle.
//    Peak throughput is one access per LATENCY+2 cycles.
//  - Byte offset off = req_addr-BASE_ADDR; word index = off[31:2].
//  - Error when any of the following holds:
//      off >= DEPTH_WORDS*4 (unsigned; addresses below BASE wrap to large values and error);
//      half access with off[0]!=0; word access with off[1:0]!=0;
//      load funct3 in {3,6,7}; store funct3 >= 3.
//    On error: no array write, rsp_rdata=0, rsp_error=1, full normal latency.
//  - Stores use byte lanes selected by off[1:0]. SB writes 1 lane from wdata[7:0]. SH writes 2 lanes from wdata[15:0]. Other lanes unchanged.
//  - Loads: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word. Lane selected by off[1:0].
//  - Store response: rsp_rdata=0, rsp_error=0.
//  - Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_busy=0, counter=0.
//  - Reset during WAIT or RESP aborts the access. A store that has not yet entered RESP is never written; a store already committed stays written.
//  - Array contents are not affected by reset; they are undefined until first written.
//  - req_valid while not ready: ignored, no state effect. Requester must hold the request until accepted.
//  - rsp_ready while rsp_valid=0: ignored.
// TESTING
//  1. LATENCY=2: SW addr 0x10 data 0xDEADBEEF, accept cycle T -> rsp_valid at T+3, rsp_error=0. Then LW 0x10 -> rsp_rdata 0xDEADBEEF.
//  2. SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
//  3. LH 0x11 -> rsp_error=1, rsp_rdata=0. SW 0x12 -> rsp_error=1 and word 0x10 unchanged. LW DEPTH_WORDS*4 -> rsp_error=1. Load funct3=3 -> rsp_error=1.
//  4. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata held stable, req_ready=0. rsp_ready=1 -> IDLE next cycle, req_ready=1.
//  5. LATENCY=0: back-to-back requests with rsp_ready=1 -> responses at T+1, next accept at T+2.
//  6. SW 0x20 data 0x11223344, reset asserted in the WAIT cycle -> rsp_valid=0, req_ready=1 after reset. Then LW 0x20 -> old contents, not 0x11223344.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding RV32I load/store target with a
// fixed access latency, valid/ready request and response channels, and
// alignment/range/funct3 error reporting.
module data_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_busy
);

  localparam int         AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic        accept, commit;

  // Request fields captured at accept
  logic        write_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  // Access source: live inputs while idle (zero-latency commit), else captured fields
  logic        acc_write;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] off;
  logic [1:0]  lane;
  logic [AW-1:0] word_idx;
  logic        acc_error;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  // Pick byte lane(s) out of a word and extend per load type
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  ln);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {ln, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    return 32'(b);
      3'd1:    return 32'(h);
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Merge right-justified store data into the selected byte lanes of a word
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  ln);
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] res;
    case (f3)
      3'd0:    begin be = 4'b0001 << ln; data = {4{wd[7:0]}};  end
      3'd1:    begin be = 4'b0011 << ln; data = {2{wd[15:0]}}; end
      default: begin be = 4'b1111;       data = wd;            end
    endcase
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = be[i] ? data[i*8 +: 8] : old[i*8 +: 8];
    return res;
  endfunction

  assign req_ready = (state == IDLE);
  assign mem_busy  = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // Address decode, error classification and array read for the current access
  always_comb begin
    acc_write  = write_p0;
    acc_funct3 = funct3_p0;
    acc_addr   = addr_p0;
    acc_wdata  = wdata_p0;
    if (state == IDLE) begin
      acc_write  = req_write;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end
    off      = acc_addr - BASE_ADDR;
    lane     = off[1:0];
    word_idx = off[AW+1:2];
    acc_error = ({1'b0, off} >= LIMIT);
    if (acc_funct3[1:0] == 2'b01 && off[0] != 1'b0)    acc_error = 1'b1;
    if (acc_funct3[1:0] == 2'b10 && off[1:0] != 2'b00) acc_error = 1'b1;
    if (acc_write) begin
      if (acc_funct3 >= 3'd3) acc_error = 1'b1;
    end else begin
      if (acc_funct3 == 3'd3 || acc_funct3 == 3'd6 || acc_funct3 == 3'd7) acc_error = 1'b1;
    end
    rd_word = mem[word_idx];
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt == 32'd0) state_nxt = RESP;
      RESP: if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The access takes effect on the edge that enters RESP; reset suppresses it
  assign commit = !reset && (state_nxt == RESP) && (state != RESP);

  // Wait-cycle counter
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= 32'd0;
    else if (accept && LATENCY > 0)
      cnt <= 32'(LATENCY) - 32'd1;
    else if (state == WAIT && cnt != 32'd0)
      cnt <= cnt - 32'd1;
  end

  // Capture request fields at accept
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0  <= req_write;
      funct3_p0 <= req_funct3;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
  end

  // Response registers, loaded at commit and held until the handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_error <= acc_error;
      rsp_rdata <= (acc_write || acc_error) ? 32'd0
                                            : load_extract(rd_word, acc_funct3, lane);
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Storage array write; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (commit && acc_write && !acc_error)
      mem[word_idx] <= store_merge(rd_word, acc_wdata, acc_funct3, lane);
  end

endmodule
